// File: rtl/traffic_pkg.sv
// Shared types for the traffic light controller and its sensor front end.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        TRACK = 2'd2,
        GAP   = 2'd3
    } cond_state_e;

    // Light encoding used by the downstream controller
    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Sensor-side bundle: raw vehicle sensor in, conditioned request and status out.
interface sensor_conditioner_if #(
    parameter int EVT_W = 8
) ();
    logic             sensor_raw;
    logic             s;
    logic             sensor_stable;
    logic [EVT_W-1:0] event_count;
    logic             busy;

    modport master (
        output sensor_raw,
        input  s, sensor_stable, event_count, busy
    );

    modport slave (
        input  sensor_raw,
        output s, sensor_stable, event_count, busy
    );
endinterface

// File: rtl/sensor_conditioner_sync_debounce.sv
// Metastability synchroniser followed by a consecutive-sample debouncer.
module sync_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stable_q, stable_d;
    logic [CNT_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic                   ss;

    assign ss     = sync_q[SYNC_STAGES-1];
    assign stable = stable_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    // Any sample agreeing with the current level restarts the count
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        if (ss != stable_q) begin
            if (deb_cnt_q == DEB_LAST) stable_d  = ss;
            else                       deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q  <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end
endmodule

// File: rtl/sensor_conditioner.sv
// Turns the raw roadside sensor into a clean request with minimum hold and off-gap.
module sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int MIN_HOLD    = 8,
    parameter int GAP_CYCLES  = 6,
    parameter int CNT_W       = 8,
    parameter int EVT_W       = 8
) (
    input logic                 clk,
    input logic                 rst,
    sensor_conditioner_if.slave bus
);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    cond_state_e      state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [EVT_W-1:0] evt_q, evt_d, evt_inc;
    logic             s_q, s_d;
    logic             busy_q, busy_d;
    logic             stable;

    sync_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_sync_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.sensor_raw),
        .stable(stable)
    );

    assign evt_inc = (&evt_q) ? evt_q : evt_q + 1'b1;

    // Timer expiry takes priority over the sensor level in timed states
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        evt_d   = evt_q;
        case (state_q)
            IDLE: begin
                if (stable) begin
                    state_d = HOLD;
                    timer_d = HOLD_LOAD;
                    evt_d   = evt_inc;
                end
            end
            HOLD: begin
                if (timer_q == '0) begin
                    if (stable) begin
                        state_d = TRACK;
                    end else begin
                        state_d = GAP;
                        timer_d = GAP_LOAD;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            TRACK: begin
                if (!stable) begin
                    state_d = GAP;
                    timer_d = GAP_LOAD;
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    if (stable) begin
                        state_d = HOLD;
                        timer_d = HOLD_LOAD;
                        evt_d   = evt_inc;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        s_d    = (state_d == HOLD) || (state_d == TRACK);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            evt_q   <= '0;
            s_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            evt_q   <= evt_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.s             = s_q;
    assign bus.busy          = busy_q;
    assign bus.event_count   = evt_q;
    assign bus.sensor_stable = stable;
endmodule
